hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Parametrised hazard-detection and stall sequencer for the 5-stage RV32I pipeline; it is the next generation of the control unit's hazard logic.
- It decodes the instruction in the decode stage and tracks in-flight producers in a 2-entry scoreboard (E, M).
- It inserts a configurable number of bubbles for load-use, load-branch and ALU-branch hazards, and freezes the pipeline for a configurable data-memory latency.
- Its outputs drive the PC, F/D and downstream pipeline-register enables.

Parameters:
- INSTR_W, 32, instruction width
- REG_LOG, 5, register index width
- LOAD_USE_BUBBLES, 1, bubbles for a load in E feeding a non-branch consumer (0..7)
- LOAD_BR_BUBBLES, 2, bubbles for a load in E feeding a branch (0..7)
- ALU_BR_BUBBLES, 1, bubbles for a non-load producer in E feeding a branch (0..7)
- MEM_DELAY, 2, freeze cycles when a load or store enters M; 0 disables the freeze (0..15)

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- instr_in, in, INSTR_W, instruction currently in decode
- instr_valid, in, 1, instr_in is a real instruction (0 = NOP/bubble)
- ext_stall, in, 1, external global freeze
- flush, in, 1, branch mispredict: kill the decode instruction; held by the source until pipe_adv=1
- pc_en, out, 1, PC update enable
- fd_en, out, 1, F/D register enable
- de_bubble, out, 1, load a NOP into D/E instead of the decoded instruction
- fd_flush, out, 1, clear F/D (mispredict)
- pipe_adv, out, 1, enable for the D/E, E/M and M/W registers
- state_o, out, 2, 0 = RUN, 1 = BUBBLE, 2 = MEM_WAIT

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset: state RUN, bubble counter 0, memory counter 0, scoreboard entries invalid. While rst=1, all outputs are 0.
- Decode uses the RV32I opcode field instr_in[6:0]:
  - rs1 is used by every opcode except jal, lui and auipc.
  - rs2 is used only by rtype, store and branch.
  - rd is written by every opcode except store and branch. rd=x0 never counts as a producer.
  - Unknown opcode: no register use, rd not written.
  - instr_valid=0: no register use, rd not written.
- Scoreboard entry = {valid, rd, is_load, is_mem}.
  - On a pipe_adv cycle: entry1 <= entry0; entry0 <= decoded instruction, or invalid if de_bubble, fd_flush or !instr_valid.
  - When pipe_adv=0, the scoreboard holds.
- Hazard (evaluated in RUN only) is a match of a used rs1/rs2 against a valid entry0.rd != 0. Required bubbles N:
  - entry0.is_load and decode is a branch: N = LOAD_BR_BUBBLES.
  - entry0.is_load and decode is not a branch: N = LOAD_USE_BUBBLES.
  - !entry0.is_load and decode is a branch: N = ALU_BR_BUBBLES.
  - Otherwise: N = 0.
- RUN outputs with N=0: pc_en=1, fd_en=1, pipe_adv=1, de_bubble=0.
- RUN outputs with N>0 (combinational, same cycle): pc_en=0, fd_en=0, de_bubble=1, pipe_adv=1. Bubble counter <= N-1. Next state is BUBBLE if N>1, else RUN.
- BUBBLE:
  - Outputs as in a hazard cycle; no re-check.
  - Counter decrements; exit to RUN when the counter reads 1 at the clock edge.
  - Total bubbles inserted = N exactly.
- MEM_WAIT entry: on any pipe_adv cycle with MEM_DELAY>0, valid entry0 and entry0.is_mem, next state is MEM_WAIT with memory counter = MEM_DELAY.
  - This takes precedence over BUBBLE/RUN as the next state.
  - The bubble counter keeps any remaining count.
- MEM_WAIT:
  - pc_en, fd_en, pipe_adv and de_bubble are all 0.
  - Memory counter decrements every cycle, including while ext_stall=1.
  - At count 1, exit to BUBBLE if the bubble counter > 0, else RUN.
  - The freeze lasts exactly MEM_DELAY cycles.
- ext_stall=1: all enables 0, fd_flush=0, state and bubble counter hold (memory counter still counts).
- Flush handling (only in a RUN or BUBBLE cycle with ext_stall=0):
  - Drives fd_flush=1, de_bubble=1, pipe_adv=1, pc_en=1, fd_en=1.
  - Clears the bubble counter; next state is RUN, unless MEM_WAIT entry applies.
  - Flush overrides hazard bubbles.
  - While frozen (MEM_WAIT or ext_stall), flush is ignored; the source holds it.
- Output priority: rst > ext_stall > MEM_WAIT > flush > BUBBLE > hazard > normal.
- Counters saturate at 0. The state register never holds an illegal encoding; encoding 3 recovers to RUN.

Test Plan:
- Reset then ALU stream (addi x1; add x2,x1,x1): pc_en=fd_en=pipe_adv=1 every cycle, de_bubble=0, state_o=0.
- lw x5,0(x1) then add x6,x5,x0, with MEM_DELAY=0: exactly 1 cycle with de_bubble=1, pc_en=0; add issues next cycle. Repeat with consumer add x6,x0,x7: 0 bubbles.
- lw x5 then beq x5,x0, with MEM_DELAY=0, LOAD_BR_BUBBLES=2: 2 consecutive bubble cycles (state_o 0 then 1), then RUN. addi x3 then beq x3: 1 bubble.
- sw with MEM_DELAY=2: after sw's D/E advance, 1 more advance cycle, then 2 cycles all-zero enables with state_o=2, then RUN. lw x5 then beq x5 with MEM_DELAY=2: 1 bubble, 2 freeze, 1 bubble.
- flush asserted in the first BUBBLE cycle: fd_flush=1, counter cleared, RUN next. flush during MEM_WAIT: fd_flush stays 0 until the freeze ends.
- ext_stall asserted mid-BUBBLE for 3 cycles: enables 0, state and counter held; on release, the remaining bubbles complete. Async rst mid-MEM_WAIT: outputs 0 immediately, state_o=0 after release.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall sequencer for a 5-stage RV32I pipeline: decodes the
// D-stage instruction, tracks E/M producers, and drives bubble/freeze/flush enables.
module hazard_stall_unit #(
  parameter int INSTR_W          = 32,
  parameter int REG_LOG          = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int LOAD_BR_BUBBLES  = 2,
  parameter int ALU_BR_BUBBLES   = 1,
  parameter int MEM_DELAY        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic               ext_stall,
  input  logic               flush,
  output logic               pc_en,
  output logic               fd_en,
  output logic               de_bubble,
  output logic               fd_flush,
  output logic               pipe_adv,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {RUN = 2'd0, BUBBLE = 2'd1, MEM_WAIT = 2'd2} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] LU_N  = 3'(LOAD_USE_BUBBLES);
  localparam logic [2:0] LB_N  = 3'(LOAD_BR_BUBBLES);
  localparam logic [2:0] AB_N  = 3'(ALU_BR_BUBBLES);
  localparam logic [3:0] MEM_N = 4'(MEM_DELAY);

  state_t             state, state_n;
  logic [2:0]         bub_cnt, bub_n;
  logic [3:0]         mem_cnt, mem_n;

  logic               e0_valid, e1_valid;
  logic [REG_LOG-1:0] e0_rd, e1_rd;
  logic               e0_ld, e0_mem, e1_ld, e1_mem;

  logic [6:0]         opcode;
  logic [REG_LOG-1:0] rd, rs1, rs2;
  logic               use_rs1, use_rs2, wr_rd, is_br, is_ld, is_st;
  logic               hazard;
  logic [2:0]         need;
  logic               pc_c, fd_c, bub_c, flush_c, adv_c;

  // The M-stage entry is tracked for observability; no current hazard rule reads it.
  logic unused_sig;
  assign unused_sig = ^{instr_in, e1_valid, e1_rd, e1_ld, e1_mem};

  assign opcode = instr_in[6:0];
  assign rd     = instr_in[7 +: REG_LOG];
  assign rs1    = instr_in[15 +: REG_LOG];
  assign rs2    = instr_in[20 +: REG_LOG];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    is_br   = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    if (instr_valid) begin
      case (opcode)
        OP_LUI, OP_AUIPC, OP_JAL: wr_rd = 1'b1;
        OP_JALR, OP_IMM: begin
          use_rs1 = 1'b1;
          wr_rd   = 1'b1;
        end
        OP_LOAD: begin
          use_rs1 = 1'b1;
          wr_rd   = 1'b1;
          is_ld   = 1'b1;
        end
        OP_STORE: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          is_st   = 1'b1;
        end
        OP_BRANCH: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          is_br   = 1'b1;
        end
        OP_REG: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          wr_rd   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hazard = e0_valid && (e0_rd != '0) &&
                  ((use_rs1 && rs1 == e0_rd) || (use_rs2 && rs2 == e0_rd));

  always_comb begin
    need = 3'd0;
    if (hazard) begin
      if (e0_ld) need = is_br ? LB_N : LU_N;
      else       need = is_br ? AB_N : 3'd0;
    end
  end

  always_comb begin
    pc_c    = 1'b0;
    fd_c    = 1'b0;
    bub_c   = 1'b0;
    flush_c = 1'b0;
    adv_c   = 1'b0;
    bub_n   = bub_cnt;
    mem_n   = (mem_cnt != 4'd0) ? mem_cnt - 4'd1 : 4'd0;
    state_n = (state == BUBBLE || state == MEM_WAIT) ? state : RUN;
    if (state == MEM_WAIT) begin
      // The freeze is timed by the memory, so it drains even under ext_stall.
      if (mem_cnt <= 4'd1) state_n = (bub_cnt != 3'd0) ? BUBBLE : RUN;
    end else if (ext_stall) begin
      state_n = (state == BUBBLE) ? BUBBLE : RUN;
    end else begin
      adv_c = 1'b1;
      if (flush) begin
        flush_c = 1'b1;
        bub_c   = 1'b1;
        pc_c    = 1'b1;
        fd_c    = 1'b1;
        bub_n   = 3'd0;
        state_n = RUN;
      end else if (state == BUBBLE) begin
        bub_c   = 1'b1;
        bub_n   = (bub_cnt != 3'd0) ? bub_cnt - 3'd1 : 3'd0;
        state_n = (bub_cnt <= 3'd1) ? RUN : BUBBLE;
      end else if (need != 3'd0) begin
        bub_c   = 1'b1;
        bub_n   = need - 3'd1;
        state_n = (need > 3'd1) ? BUBBLE : RUN;
      end else begin
        pc_c    = 1'b1;
        fd_c    = 1'b1;
        state_n = RUN;
      end
      if (MEM_N != 4'd0 && e0_valid && e0_mem) begin
        state_n = MEM_WAIT;
        mem_n   = MEM_N;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      bub_cnt  <= 3'd0;
      mem_cnt  <= 4'd0;
      e0_valid <= 1'b0;
      e1_valid <= 1'b0;
    end else begin
      state   <= state_n;
      bub_cnt <= bub_n;
      mem_cnt <= mem_n;
      if (adv_c) begin
        e1_valid <= e0_valid;
        e0_valid <= instr_valid && !bub_c && !flush_c;
      end
    end
  end

  // Scoreboard payload only matters when its valid bit is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (adv_c) begin
      e1_rd  <= e0_rd;
      e1_ld  <= e0_ld;
      e1_mem <= e0_mem;
      e0_rd  <= wr_rd ? rd : '0;
      e0_ld  <= is_ld;
      e0_mem <= is_ld || is_st;
    end
  end

  assign pc_en     = pc_c & ~rst;
  assign fd_en     = fd_c & ~rst;
  assign de_bubble = bub_c & ~rst;
  assign fd_flush  = flush_c & ~rst;
  assign pipe_adv  = adv_c & ~rst;
  assign state_o   = rst ? 2'd0 : state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: DUT a has no memory freeze, DUT b a 2-cycle freeze.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_a = '0, instr_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ext_a = 1'b0, ext_b = 1'b0;
  logic        flush_a = 1'b0, flush_b = 1'b0;
  logic        pc_a, fd_a, bub_a, fl_a, adv_a;
  logic        pc_b, fd_b, bub_b, fl_b, adv_b;
  logic [1:0]  st_a, st_b;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_DELAY(0)) dut_a (
    .clk(clk), .rst(rst), .instr_in(instr_a), .instr_valid(valid_a),
    .ext_stall(ext_a), .flush(flush_a), .pc_en(pc_a), .fd_en(fd_a),
    .de_bubble(bub_a), .fd_flush(fl_a), .pipe_adv(adv_a), .state_o(st_a));

  hazard_stall_unit #(.MEM_DELAY(2)) dut_b (
    .clk(clk), .rst(rst), .instr_in(instr_b), .instr_valid(valid_b),
    .ext_stall(ext_b), .flush(flush_b), .pc_en(pc_b), .fd_en(fd_b),
    .de_bubble(bub_b), .fd_flush(fl_b), .pipe_adv(adv_b), .state_o(st_b));

  // Output vector: {pc_en, fd_en, de_bubble, fd_flush, pipe_adv, state_o}
  localparam logic [6:0] NORM    = 7'b1100100;
  localparam logic [6:0] HAZ     = 7'b0010100;
  localparam logic [6:0] BUB     = 7'b0010101;
  localparam logic [6:0] STALL_B = 7'b0000001;
  localparam logic [6:0] STALL_R = 7'b0000000;
  localparam logic [6:0] FRZ     = 7'b0000010;
  localparam logic [6:0] FLB     = 7'b1111101;
  localparam logic [6:0] FLR     = 7'b1111100;
  localparam logic [6:0] ZERO    = 7'b0000000;

  localparam logic [6:0] OPI = 7'h13, OPR = 7'h33, OPL = 7'h03, OPS = 7'h23, OPB = 7'h63;

  typedef struct {
    int         dut;
    logic [6:0] bits;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  task automatic step(input int d, input logic [31:0] ins, input logic v, input logic es,
                      input logic fl, input logic r, input logic [6:0] ex, input string nm);
    exp_t e;
    rst = r;
    if (d == 0) begin
      instr_a = ins; valid_a = v; ext_a = es; flush_a = fl;
      valid_b = 1'b0; ext_b = 1'b0; flush_b = 1'b0;
    end else begin
      instr_b = ins; valid_b = v; ext_b = es; flush_b = fl;
      valid_a = 1'b0; ext_a = 1'b0; flush_a = 1'b0;
    end
    e.dut = d; e.bits = ex; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational in the cycle, so sample at mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t       e;
      logic [6:0] act;
      e = q.pop_front();
      act = (e.dut == 0) ? {pc_a, fd_a, bub_a, fl_a, adv_a, st_a}
                         : {pc_b, fd_b, bub_b, fl_b, adv_b, st_b};
      n_cmp++;
      if (act !== e.bits) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (pc fd bub flush adv state)", e.name, act, e.bits);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] addi1, add2, add3, lw5, use5, nouse, beq5, addi3, beq3, addi9, sw5, addi7, addi8;
    addi1 = enc(OPI, 5'd1, 5'd0, 5'd0);
    add2  = enc(OPR, 5'd2, 5'd1, 5'd1);
    add3  = enc(OPR, 5'd3, 5'd2, 5'd1);
    lw5   = enc(OPL, 5'd5, 5'd1, 5'd0);
    use5  = enc(OPR, 5'd6, 5'd5, 5'd0);
    nouse = enc(OPR, 5'd6, 5'd0, 5'd7);
    beq5  = enc(OPB, 5'd0, 5'd5, 5'd0);
    addi3 = enc(OPI, 5'd3, 5'd0, 5'd0);
    beq3  = enc(OPB, 5'd0, 5'd3, 5'd0);
    addi9 = enc(OPI, 5'd9, 5'd0, 5'd0);
    sw5   = enc(OPS, 5'd0, 5'd1, 5'd5);
    addi7 = enc(OPI, 5'd7, 5'd0, 5'd0);
    addi8 = enc(OPI, 5'd8, 5'd0, 5'd0);

    @(posedge clk);
    #1;
    step(0, addi1, 1, 0, 0, 1, ZERO, "reset_a");
    step(1, addi1, 1, 0, 0, 1, ZERO, "reset_b");

    // ALU stream, no hazards
    step(0, addi1, 1, 0, 0, 0, NORM, "alu_addi");
    step(0, add2,  1, 0, 0, 0, NORM, "alu_add_dep");
    step(0, add3,  1, 0, 0, 0, NORM, "alu_add_dep2");

    // Load-use: one bubble, then unrelated consumer: none
    step(0, lw5,   1, 0, 0, 0, NORM, "lu_load");
    step(0, use5,  1, 0, 0, 0, HAZ,  "lu_bubble");
    step(0, use5,  1, 0, 0, 0, NORM, "lu_issue");
    step(0, lw5,   1, 0, 0, 0, NORM, "lu2_load");
    step(0, nouse, 1, 0, 0, 0, NORM, "lu2_nodep");

    // Load-branch: two bubbles; ALU-branch: one
    step(0, lw5,   1, 0, 0, 0, NORM, "lb_load");
    step(0, beq5,  1, 0, 0, 0, HAZ,  "lb_bubble1");
    step(0, beq5,  1, 0, 0, 0, BUB,  "lb_bubble2");
    step(0, beq5,  1, 0, 0, 0, NORM, "lb_issue");
    step(0, addi3, 1, 0, 0, 0, NORM, "ab_addi");
    step(0, beq3,  1, 0, 0, 0, HAZ,  "ab_bubble");
    step(0, beq3,  1, 0, 0, 0, NORM, "ab_issue");

    // Flush in the first BUBBLE cycle clears the remaining count
    step(0, lw5,   1, 0, 0, 0, NORM, "fl_load");
    step(0, beq5,  1, 0, 0, 0, HAZ,  "fl_hazard");
    step(0, beq5,  1, 0, 1, 0, FLB,  "fl_in_bubble");
    step(0, addi9, 1, 0, 0, 0, NORM, "fl_run_after");

    // ext_stall mid-BUBBLE holds state and count
    step(0, lw5,   1, 0, 0, 0, NORM,    "es_load");
    step(0, beq5,  1, 0, 0, 0, HAZ,     "es_hazard");
    step(0, beq5,  1, 1, 0, 0, STALL_B, "es_hold1");
    step(0, beq5,  1, 1, 0, 0, STALL_B, "es_hold2");
    step(0, beq5,  1, 1, 0, 0, STALL_B, "es_hold3");
    step(0, beq5,  1, 0, 0, 0, BUB,     "es_resume");
    step(0, beq5,  1, 0, 0, 0, NORM,    "es_issue");
    step(0, addi1, 1, 1, 1, 0, STALL_R, "es_run_flush_ignored");
    step(0, addi1, 1, 0, 0, 0, NORM,    "es_run_release");

    // Store with 2-cycle memory freeze
    step(1, sw5,   1, 0, 0, 0, NORM, "sw_issue");
    step(1, addi7, 1, 0, 0, 0, NORM, "sw_to_mem");
    step(1, addi8, 1, 0, 0, 0, FRZ,  "sw_freeze1");
    step(1, addi8, 1, 0, 0, 0, FRZ,  "sw_freeze2");
    step(1, addi8, 1, 0, 0, 0, NORM, "sw_resume");

    // Load-branch with freeze: 1 bubble, 2 freeze, 1 bubble
    step(1, lw5,   1, 0, 0, 0, NORM, "lbm_load");
    step(1, beq5,  1, 0, 0, 0, HAZ,  "lbm_bubble1");
    step(1, beq5,  1, 0, 0, 0, FRZ,  "lbm_freeze1");
    step(1, beq5,  1, 0, 0, 0, FRZ,  "lbm_freeze2");
    step(1, beq5,  1, 0, 0, 0, BUB,  "lbm_bubble2");
    step(1, beq5,  1, 0, 0, 0, NORM, "lbm_issue");

    // Flush held through a freeze takes effect only afterwards
    step(1, sw5,   1, 0, 0, 0, NORM, "fm_store");
    step(1, addi7, 1, 0, 0, 0, NORM, "fm_to_mem");
    step(1, addi8, 1, 0, 1, 0, FRZ,  "fm_frozen1");
    step(1, addi8, 1, 0, 1, 0, FRZ,  "fm_frozen2");
    step(1, addi8, 1, 0, 1, 0, FLR,  "fm_flush");
    step(1, addi8, 1, 0, 0, 0, NORM, "fm_after");

    // Asynchronous reset in the middle of a freeze
    step(1, sw5,   1, 0, 0, 0, NORM, "rm_store");
    step(1, addi7, 1, 0, 0, 0, NORM, "rm_to_mem");
    step(1, addi8, 1, 0, 0, 0, FRZ,  "rm_frozen");
    step(1, addi8, 1, 0, 0, 1, ZERO, "rm_reset1");
    step(1, addi8, 1, 0, 0, 1, ZERO, "rm_reset2");
    step(1, addi8, 1, 0, 0, 0, NORM, "rm_release");

    @(negedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
